// File: rtl/tqvp_multi_pwm.sv
// tqvp_multi_pwm: multi-channel PWM peripheral. All channels share one 8-bit counter
// (up or up/down) driven by a programmable prescaler. Duty levels are double-buffered:
// LEVEL is the software-visible shadow and ACTIVE is loaded from it at period boundaries.
module tqvp_multi_pwm #(
    parameter int unsigned NUM_CH = 4  // 1..8 channels
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    localparam logic [3:0] AddrTop    = 4'h8;
    localparam logic [3:0] AddrPresc  = 4'h9;
    localparam logic [3:0] AddrCtrl   = 4'hA;
    localparam logic [3:0] AddrPol    = 4'hB;
    localparam logic [3:0] AddrCount  = 4'hC;
    localparam logic [3:0] AddrStatus = 4'hD;

    localparam logic DirUp   = 1'b0;
    localparam logic DirDown = 1'b1;

    logic [7:0] level_q  [NUM_CH];
    logic [7:0] level_d  [NUM_CH];
    logic [7:0] active_q [NUM_CH];
    logic [7:0] active_d [NUM_CH];
    logic [7:0] top_q, top_d;
    logic [7:0] presc_q, presc_d;
    logic [1:0] ctrl_q, ctrl_d;  // [0] enable, [1] up/down mode
    logic [7:0] pol_q, pol_d;
    logic [7:0] count_q, count_d;
    logic [7:0] psc_q, psc_d;
    logic       dir_q, dir_d;
    logic       wrap_q, wrap_d;
    logic [7:0] uo_q, uo_d;

    logic en, updn, tick, boundary;

    // The input PMOD has no function in this block.
    logic unused_ui;
    assign unused_ui = ^ui_in;

    assign en     = ctrl_q[0];
    assign updn   = ctrl_q[1];
    assign uo_out = uo_q;

    // Next-state: register writes, prescaler, counter, double-buffer load and outputs.
    always_comb begin
        level_d  = level_q;
        active_d = active_q;
        top_d    = top_q;
        presc_d  = presc_q;
        ctrl_d   = ctrl_q;
        pol_d    = pol_q;
        count_d  = count_q;
        psc_d    = psc_q;
        dir_d    = dir_q;
        wrap_d   = wrap_q;
        uo_d     = 8'h00;
        tick     = 1'b0;
        boundary = 1'b0;

        if (data_write) begin
            case (address)
                AddrTop:    top_d   = data_in;
                AddrPresc:  presc_d = data_in;
                AddrCtrl:   ctrl_d  = data_in[1:0];
                AddrPol:    pol_d   = data_in;
                AddrStatus: if (data_in[0]) wrap_d = 1'b0;
                default:    ;
            endcase
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (address == 4'(i)) level_d[i] = data_in;
            end
        end

        if (!en) begin
            // Idle: everything parked so enabling starts a clean period with fresh levels.
            psc_d    = 8'h00;
            count_d  = 8'h00;
            dir_d    = DirUp;
            active_d = level_q;
        end else begin
            if (psc_q == presc_q) begin
                psc_d = 8'h00;
                tick  = 1'b1;
            end else begin
                psc_d = psc_q + 8'd1;
            end

            if (!updn) dir_d = DirUp;

            if (tick) begin
                if (!updn) begin
                    if (count_q >= top_q) begin
                        count_d  = 8'h00;
                        boundary = 1'b1;
                    end else begin
                        count_d = count_q + 8'd1;
                    end
                end else if (top_q == 8'h00) begin
                    count_d  = 8'h00;
                    dir_d    = DirUp;
                    boundary = 1'b1;
                end else if (dir_q == DirUp) begin
                    if (count_q >= top_q) begin
                        dir_d   = DirDown;
                        count_d = top_q - 8'd1;
                    end else begin
                        count_d = count_q + 8'd1;
                    end
                end else if (count_q == 8'h00) begin
                    dir_d    = DirUp;
                    count_d  = 8'h01;
                    boundary = 1'b1;
                end else begin
                    count_d = count_q - 8'd1;
                end
            end

            // Loads the pre-write LEVEL, so a same-cycle write lands one period later.
            if (boundary) begin
                active_d = level_q;
                wrap_d   = 1'b1;
            end
        end

        for (int unsigned i = 0; i < NUM_CH; i++) begin
            uo_d[i] = en ? ((count_q < active_q[i]) ^ pol_q[i]) : pol_q[i];
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                level_q[i]  <= 8'h00;
                active_q[i] <= 8'h00;
            end
            top_q   <= 8'hFE;
            presc_q <= 8'h00;
            ctrl_q  <= 2'b01;
            pol_q   <= 8'h00;
            count_q <= 8'h00;
            psc_q   <= 8'h00;
            dir_q   <= DirUp;
            wrap_q  <= 1'b0;
            uo_q    <= 8'h00;
        end else begin
            level_q  <= level_d;
            active_q <= active_d;
            top_q    <= top_d;
            presc_q  <= presc_d;
            ctrl_q   <= ctrl_d;
            pol_q    <= pol_d;
            count_q  <= count_d;
            psc_q    <= psc_d;
            dir_q    <= dir_d;
            wrap_q   <= wrap_d;
            uo_q     <= uo_d;
        end
    end

    // Combinational read mux; unmapped and absent-channel addresses read 0.
    always_comb begin
        data_out = 8'h00;
        case (address)
            AddrTop:    data_out = top_q;
            AddrPresc:  data_out = presc_q;
            AddrCtrl:   data_out = {6'b0, ctrl_q};
            AddrPol:    data_out = pol_q;
            AddrCount:  data_out = count_q;
            AddrStatus: data_out = {7'b0, wrap_q};
            default:    ;
        endcase
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (address == 4'(i)) data_out = level_q[i];
        end
    end

endmodule

// File: tb/tb_tqvp_multi_pwm.sv
// Testbench for tqvp_multi_pwm: directed period/duty scenarios plus randomized runs,
// checked against a closed-form model of the counter and boundary timing.
module tb_tqvp_multi_pwm;

    localparam int unsigned NUM_CH  = 4;
    localparam logic [7:0]  CH_MASK = 8'h0F;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;

    int checks   = 0;
    int failures = 0;

    tqvp_multi_pwm #(.NUM_CH(NUM_CH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ui_in      (ui_in),
        .uo_out     (uo_out),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data_write = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
        address    = a;
        data_write = 1'b0;
        #1;
        check(tag, {24'h0, data_out}, {24'h0, exp});
    endtask

    // Count value after k enabled edges: n = ticks so far, then a sawtooth or triangle.
    function automatic int ref_count(input int k, input int t, input int p, input bit updn);
        int n;
        int pos;
        n = k / (p + 1);
        if (!updn) return n % (t + 1);
        if (t == 0) return 0;
        pos = n % (2 * t);
        return (pos <= t) ? pos : 2 * t - pos;
    endfunction

    // Whether enabled edge k is a period boundary.
    function automatic bit ref_boundary(input int k, input int t, input int p, input bit updn);
        int n;
        if (k < 1 || (k % (p + 1)) != 0) return 1'b0;
        n = k / (p + 1);
        if (!updn) return (n % (t + 1)) == 0;
        if (t == 0) return 1'b1;
        return n > 1 && ((n - 1) % (2 * t)) == 0;
    endfunction

    task automatic run_scenario(input string name, input int t, input int p, input bit updn,
                                input logic [7:0] pol, input logic [31:0] levels,
                                input int ncyc, input bit rand_wr, input int win,
                                output int hi0);
        logic [7:0] lev [NUM_CH];
        logic [7:0] act [NUM_CH];
        logic [7:0] cnt_prev;
        logic [7:0] exp_uo;
        logic [7:0] wr_val;
        logic [3:0] wr_addr;
        logic       bnd;
        logic       wrap;
        int         op;

        // Configure while disabled.
        bus_write(4'hA, {6'b0, updn, 1'b0});
        bus_write(4'h8, 8'(t));
        bus_write(4'h9, 8'(p));
        bus_write(4'hB, pol);
        for (int c = 0; c < NUM_CH; c++) begin
            lev[c] = levels[8*c +: 8];
            bus_write(4'(c), lev[c]);
        end
        bus_write(4'hD, 8'h01);
        check({name, " off uo"}, {24'h0, uo_out}, {24'h0, pol & CH_MASK});
        read_check({name, " off count"}, 4'hC, 8'h00);
        read_check({name, " off status"}, 4'hD, 8'h00);
        read_check({name, " top rb"}, 4'h8, 8'(t));
        read_check({name, " presc rb"}, 4'h9, 8'(p));
        read_check({name, " ctrl rb"}, 4'hA, {6'b0, updn, 1'b0});
        read_check({name, " pol rb"}, 4'hB, pol);
        read_check({name, " level0 rb"}, 4'h0, lev[0]);
        read_check({name, " level3 rb"}, 4'h3, lev[3]);
        act = lev;

        // Enable edge is edge 0; output still reflects the disabled state.
        bus_write(4'hA, {6'b0, updn, 1'b1});
        check({name, " en edge uo"}, {24'h0, uo_out}, {24'h0, pol & CH_MASK});
        cnt_prev = 8'h00;
        wrap     = 1'b0;
        hi0      = 0;

        for (int k = 1; k <= ncyc; k++) begin
            bnd     = ref_boundary(k, t, p, updn);
            op      = 0;
            wr_addr = 4'hC;
            wr_val  = 8'h00;
            if (rand_wr) begin
                op = $urandom_range(0, 9);
                op = (op < 2) ? 1 : ((op < 3) ? 2 : 0);
                if (bnd && $urandom_range(0, 1) == 1) op = 1 + $urandom_range(0, 1);
            end
            if (op == 1) begin
                wr_addr = 4'($urandom_range(0, 7));
                wr_val  = 8'($urandom_range(0, t + 3));
            end else if (op == 2) begin
                wr_addr = 4'hD;
                wr_val  = 8'($urandom_range(0, 1));
            end
            address    = wr_addr;
            data_in    = wr_val;
            data_write = (op != 0);

            exp_uo = 8'h00;
            for (int c = 0; c < NUM_CH; c++) exp_uo[c] = (cnt_prev < act[c]) ^ pol[c];
            if (bnd) begin
                act  = lev;
                wrap = 1'b1;
            end else if (op == 2 && wr_val[0]) begin
                wrap = 1'b0;
            end
            if (op == 1) begin
                for (int c = 0; c < NUM_CH; c++) if (wr_addr == 4'(c)) lev[c] = wr_val;
            end
            cnt_prev = 8'(ref_count(k, t, p, updn));

            @(posedge clk);
            @(negedge clk);
            data_write = 1'b0;
            check({name, " uo"}, {24'h0, uo_out}, {24'h0, exp_uo});
            read_check({name, " count"}, 4'hC, cnt_prev);
            read_check({name, " wrap"}, 4'hD, {7'b0, wrap});
            if (k <= win) hi0 += int'(uo_out[0]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int          hi0;
        logic [31:0] lv;
        int          t;

        ui_in      = 8'($urandom);
        address    = 4'h8;
        data_in    = 8'h33;
        data_write = 1'b1;  // reset must override this write
        rst_n      = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        data_write = 1'b0;

        check("reset uo", {24'h0, uo_out}, 32'h0);
        read_check("reset top", 4'h8, 8'hFE);
        read_check("reset presc", 4'h9, 8'h00);
        read_check("reset ctrl", 4'hA, 8'h01);
        read_check("reset pol", 4'hB, 8'h00);
        read_check("reset count", 4'hC, 8'h00);
        read_check("reset status", 4'hD, 8'h00);
        read_check("reset level0", 4'h0, 8'h00);
        read_check("reset level3", 4'h3, 8'h00);

        // Absent channels and unmapped addresses read 0 and ignore writes.
        bus_write(4'h5, 8'hA5);
        read_check("absent level5", 4'h5, 8'h00);
        read_check("unmapped e", 4'hE, 8'h00);
        read_check("unmapped f", 4'hF, 8'h00);

        run_scenario("dflt128", 254, 0, 1'b0, 8'h00, 32'h33FF0080, 3 * 255 + 3, 1'b0, 255, hi0);
        check("dflt128 high clocks", hi0, 128);
        run_scenario("pol06", 254, 0, 1'b0, 8'h06, 32'h33FF0080, 3 * 255 + 3, 1'b0, 255, hi0);
        check("pol06 high clocks", hi0, 128);
        run_scenario("presc", 9, 1, 1'b0, 8'h00, 32'h05020103, 60, 1'b0, 20, hi0);
        check("presc high clocks", hi0, 6);
        run_scenario("updn", 4, 0, 1'b1, 8'h00, 32'h05030002, 40, 1'b0, 8, hi0);
        check("updn high clocks", hi0, 3);
        run_scenario("midwr", 20, 0, 1'b0, 8'h00, 32'h08040210, 100, 1'b1, 0, hi0);

        for (int s = 0; s < 10; s++) begin
            t = $urandom_range(0, 12);
            for (int c = 0; c < 4; c++) lv[8*c +: 8] = 8'($urandom_range(0, t + 2));
            run_scenario("rand", t, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                         8'($urandom_range(0, 15)), lv, 120, 1'b1, 0, hi0);
        end

        // Reset mid-run with a coincident write.
        bus_write(4'hB, 8'h09);
        bus_write(4'h1, 8'h44);
        address    = 4'h9;
        data_in    = 8'h55;
        data_write = 1'b1;
        rst_n      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        data_write = 1'b0;
        check("midrst uo", {24'h0, uo_out}, 32'h0);
        read_check("midrst top", 4'h8, 8'hFE);
        read_check("midrst presc", 4'h9, 8'h00);
        read_check("midrst ctrl", 4'hA, 8'h01);
        read_check("midrst pol", 4'hB, 8'h00);
        read_check("midrst count", 4'hC, 8'h00);
        read_check("midrst status", 4'hD, 8'h00);
        read_check("midrst level1", 4'h1, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tqvp_multi_pwm.md
TQVP_MULTI_PWM -- requirements
Module: tqvp_multi_pwm

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, legal range 1..8, giving the number of independent PWM channels.
REQ-002 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit, synchronous active-low reset.
REQ-004 The block SHALL have port ui_in, input, 8 bits, input PMOD, unused.
REQ-005 The block SHALL have port uo_out, output, 8 bits, where bit i is channel i PWM for i<NUM_CH and bits >=NUM_CH are 0.
REQ-006 The block SHALL have port address, input, 4 bits, register select.
REQ-007 The block SHALL have port data_write, input, 1 bit, a one-cycle write strobe.
REQ-008 The block SHALL have port data_in, input, 8 bits, write data, valid with data_write.
REQ-009 The block SHALL have port data_out, output, 8 bits, combinational read data for the current address.

Function
REQ-010 The register map SHALL be as follows.
- 0x0..0x7: LEVEL[i], shadow duty, R/W; addresses >=NUM_CH read 0 and ignore writes.
- 0x8: TOP, period limit, R/W.
- 0x9: PRESC, prescale value, R/W.
- 0xA: CTRL, R/W; bit0 EN, bit1 UPDN (0 = up-count, 1 = up/down); other bits read 0.
- 0xB: POL, R/W; bit i inverts channel i.
- 0xC: COUNT, read-only.
- 0xD: STATUS, bit0 WRAP, sticky; writing 1 clears it.
- 0xE..0xF: read 0.
REQ-011 The prescaler SHALL count 0..PRESC and generate tick when it equals PRESC, then return to 0, so COUNT advances once every PRESC+1 clocks.
REQ-012 Up mode SHALL behave as follows on tick.
- If COUNT>=TOP: COUNT<=0, a boundary event occurs.
- Otherwise: COUNT<=COUNT+1.
- The period is TOP+1 ticks.
REQ-013 Up/down mode SHALL keep a direction bit, up at reset, and behave as follows on tick.
- Up direction:
  - COUNT>=TOP: DIR<=down, COUNT<=TOP-1.
  - Otherwise: COUNT+1.
- Down direction:
  - COUNT==0: DIR<=up, COUNT<=1, boundary event.
  - Otherwise: COUNT-1.
- TOP==0 holds COUNT at 0 with a boundary event every tick.
REQ-014 A boundary event SHALL copy every LEVEL[i] into its ACTIVE[i] (double buffering) and set STATUS.WRAP.
REQ-015 LEVEL writes SHALL affect the output only after the next boundary event.
REQ-016 A LEVEL write in the same cycle as a boundary SHALL load the pre-write LEVEL value into ACTIVE.
REQ-017 Writes to TOP, PRESC and CTRL SHALL take effect on the next clock.
REQ-018 Channel raw compare SHALL be COUNT < ACTIVE[i], 8-bit unsigned: ACTIVE=0 gives always low, ACTIVE>TOP gives always high.
REQ-019 uo_out[i] SHALL be registered: on every clock it takes (raw[i] XOR POL[i]) when EN=1, else POL[i]; latency is 1 clock from COUNT to output.
REQ-020 When EN=0, the block SHALL hold the following state.
- Prescaler, COUNT and DIR held at 0/up.
- ACTIVE[i] follows LEVEL[i] every clock.
- WRAP not set.
REQ-021 Setting EN=1 SHALL start counting from COUNT=0 with the latest levels.
REQ-022 A WRAP W1C write coinciding with a boundary event SHALL leave WRAP=1 (set wins).
REQ-023 Switching UPDN mid-period SHALL NOT reset COUNT; in up mode DIR is forced to up.
REQ-024 All counters SHALL wrap modulo 256 and never exceed 8 bits.

Reset
REQ-025 While rst_n=0 at a clock edge, the block SHALL load the following values.
- LEVEL, ACTIVE, POL, COUNT and the prescaler = 0.
- DIR = up.
- TOP = 0xFE.
- PRESC = 0.
- CTRL = 0x01 (enabled, up mode).
- WRAP = 0.
- uo_out = 0x00.
REQ-026 Reset SHALL override any simultaneous write, and reset mid-period SHALL discard the partial period.

Verification
REQ-027 Bench: LEVEL0=0x80, defaults -> uo_out[0] high for 128 of every 255 clocks; the period edge aligns with COUNT wrap 0xFE->0x00.
REQ-028 Bench: LEVEL1=0x00 and LEVEL2=0xFF, defaults -> ch1 constant 0 and ch2 constant 1 across 3 periods; POL=0x06 inverts both.
REQ-029 Bench: TOP=9, PRESC=1, LEVEL0=3 -> period 20 clocks, high 6 clocks; COUNT reads change every 2 clocks.
REQ-030 Bench: mid-period LEVEL0 write 0x10->0x40 -> output unchanged until the next COUNT wrap, then the new duty applies; a write on the boundary cycle is deferred one period.
REQ-031 Bench: UPDN=1, TOP=4, LEVEL0=2 -> COUNT sequence 0,1,2,3,4,3,2,1,0,1...; output is centered and high while COUNT<2; WRAP sets at each 0.
REQ-032 Bench: clear WRAP with a write of 1 on the same cycle as a boundary -> WRAP reads 1; EN=0 -> uo_out=POL and COUNT reads 0; reset mid-run -> all registers return to their reset values.
